// File: rtl/arb_req_master.sv
// ============================================================================
// Module   : arb_req_master
// Purpose  : Requester-side agent for a round-robin arbiter. Buffers upstream
//            words and streams bounded bursts onto the shared bus under grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_req_master #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              err_lost,
  output logic              starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BEATS) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] C_BEAT_LAST = BW'(MAX_BEATS - 1);
  localparam logic [WW-1:0] C_WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_XFER    = 3'd2,
    S_RELEASE = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
  logic                req_q, req_d;
  logic                bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic                bus_last_q, bus_last_d;
  logic                err_lost_q, err_lost_d;
  logic                starve_q, starve_d;
  logic                push, pop;

  assign in_ready  = (count_q != C_FULL);
  assign push      = in_valid & in_ready;
  assign req       = req_q;
  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;
  assign bus_last  = bus_last_q;
  assign err_lost  = err_lost_q;
  assign starve    = starve_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    bus_valid_d = 1'b0;
    bus_last_d  = 1'b0;
    bus_data_d  = bus_data_q;
    err_lost_d  = 1'b0;
    starve_d    = starve_q;
    wait_cnt_d  = wait_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_d = 1'b0;
        if (count_q != '0 && !grant) begin
          state_d    = S_REQ;
          req_d      = 1'b1;
          wait_cnt_d = '0;
        end
      end
      S_REQ: begin
        req_d = 1'b1;
        if (grant) begin
          state_d    = S_XFER;
          beat_cnt_d = '0;
          starve_d   = 1'b0;
        end else begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == C_WAIT_LAST) starve_d = 1'b1;
        end
      end
      S_XFER: begin
        if (!grant) begin
          // Grant lost mid-burst: keep requesting, remaining words stay queued
          err_lost_d = 1'b1;
          state_d    = S_REQ;
          wait_cnt_d = '0;
        end else if (count_q == '0) begin
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end else begin
          pop         = 1'b1;
          bus_valid_d = 1'b1;
          bus_data_d  = mem[rd_ptr_q];
          beat_cnt_d  = beat_cnt_q + 1'b1;
          // A word pushed this same cycle is not counted; it waits for the next grant
          if (beat_cnt_q == C_BEAT_LAST || count_q == CW'(1)) begin
            bus_last_d = 1'b1;
            req_d      = 1'b0;
            state_d    = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        req_d = 1'b0;
        if (!grant) state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      req_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_last_q  <= 1'b0;
      err_lost_q  <= 1'b0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      req_q       <= req_d;
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
      bus_last_q  <= bus_last_d;
      err_lost_q  <= err_lost_d;
      starve_q    <= starve_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_req_master.sv
// ============================================================================
// Module   : tb_arb_req_master
// Purpose  : Self-checking bench for arb_req_master against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_arb_req_master;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int TIMEOUT   = 64;

  localparam int P_QUIET = 0;
  localparam int P_ASK   = 1;
  localparam int P_SEND  = 2;
  localparam int P_LETGO = 3;
  localparam int P_GAP   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              grant = 1'b0;
  logic              in_ready, req, bus_valid, bus_last, err_lost, starve;
  logic [DATA_W-1:0] bus_data;

  arb_req_master #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req(req), .grant(grant), .bus_valid(bus_valid),
    .bus_data(bus_data), .bus_last(bus_last), .err_lost(err_lost), .starve(starve)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending words as a queue, plus the agent's current phase
  logic [DATA_W-1:0] mq[$];
  int   ph, waited, beats;
  logic m_req, m_bv, m_bl, m_err, m_starve;
  logic [DATA_W-1:0] m_bd;

  logic [DATA_W:0] beat_log[$];
  int err_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    mq.delete();
    ph = P_QUIET; waited = 0; beats = 0;
    m_req = 0; m_bv = 0; m_bl = 0; m_err = 0; m_starve = 0; m_bd = '0;
  endtask

  task automatic model_step;
    int cnt;
    bit do_push;
    cnt = mq.size();
    do_push = in_valid && (cnt < DEPTH);
    m_bv = 0; m_bl = 0; m_err = 0;
    case (ph)
      P_QUIET: if (cnt > 0 && !grant) begin ph = P_ASK; m_req = 1; waited = 0; end
      P_ASK: begin
        if (grant) begin ph = P_SEND; beats = 0; m_starve = 0; end
        else begin waited++; if (waited >= TIMEOUT) m_starve = 1; end
      end
      P_SEND: begin
        if (!grant) begin m_err = 1; ph = P_ASK; waited = 0; end
        else if (cnt == 0) begin m_req = 0; ph = P_LETGO; end
        else begin
          m_bd = mq.pop_front(); m_bv = 1; beats++;
          if (beats == MAX_BEATS || cnt == 1) begin m_bl = 1; m_req = 0; ph = P_LETGO; end
        end
      end
      P_LETGO: if (!grant) ph = P_GAP;
      P_GAP:   ph = P_QUIET;
      default: ph = P_QUIET;
    endcase
    if (do_push) mq.push_back(in_data);
  endtask

  task automatic compare_all;
    chk("req",       req,       m_req);
    chk("bus_valid", bus_valid, m_bv);
    chk("bus_data",  bus_data,  m_bd);
    chk("bus_last",  bus_last,  m_bl);
    chk("err_lost",  err_lost,  m_err);
    chk("starve",    starve,    m_starve);
    chk("in_ready",  in_ready,  (mq.size() < DEPTH));
  endtask

  // One clock: drive inputs, advance model on the edge, compare on the falling edge
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic g);
    in_valid = v; in_data = d; grant = g;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (bus_valid) beat_log.push_back({bus_last, bus_data});
    if (err_lost) err_cnt++;
  endtask

  initial begin
    int r0, s0, idx, lasts, k;
    logic rdy;
    logic [DATA_W-1:0] g;

    model_reset();
    err_cnt = 0;
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_req", req, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Three words, grant follows req with a one-cycle lag
    beat_log.delete();
    cycle(1, 32'hA0, 0); cycle(1, 32'hA1, 0); cycle(1, 32'hA2, 0);
    repeat (12) cycle(0, '0, req);
    chk("t1_beats", beat_log.size(), 3);
    chk("t1_d0", beat_log[0], {1'b0, 32'hA0});
    chk("t1_d1", beat_log[1], {1'b0, 32'hA1});
    chk("t1_d2_last", beat_log[2], {1'b1, 32'hA2});
    chk("t1_req_low", req, 0);

    // Ten words split into bursts of 4, 4, 2
    beat_log.delete();
    for (int i = 0; i < 8; i++) cycle(1, 32'hB0 + i, 0);
    for (int it = 0; it < 40; it++)
      cycle(it == 20 || it == 21, 32'hB8 + (it - 20), req);
    lasts = 0;
    foreach (beat_log[i]) if (beat_log[i][DATA_W]) lasts++;
    chk("t2_beats", beat_log.size(), 10);
    chk("t2_lasts", lasts, 3);
    chk("t2_b3_last", beat_log[3], {1'b1, 32'hB3});
    chk("t2_b7_last", beat_log[7], {1'b1, 32'hB7});
    chk("t2_b8", beat_log[8], {1'b0, 32'hB8});
    chk("t2_b9_last", beat_log[9], {1'b1, 32'hB9});

    // Grant withdrawn after two beats of four
    beat_log.delete(); err_cnt = 0;
    for (int i = 0; i < 4; i++) cycle(1, 32'hC0 + i, 0);
    cycle(0, '0, 1); cycle(0, '0, 1); cycle(0, '0, 1);
    cycle(0, '0, 0);
    chk("t3_err_pulse", err_lost, 1);
    chk("t3_req_held", req, 1);
    cycle(0, '0, 0);
    chk("t3_err_once", err_cnt, 1);
    chk("t3_partial", beat_log.size(), 2);
    repeat (15) cycle(0, '0, req);
    chk("t3_beats", beat_log.size(), 4);
    chk("t3_c1", beat_log[1], {1'b0, 32'hC1});
    chk("t3_c2", beat_log[2], {1'b0, 32'hC2});
    chk("t3_c3_last", beat_log[3], {1'b1, 32'hC3});

    // Starvation flag after TIMEOUT wait cycles
    r0 = -1; s0 = -1;
    for (int i = 0; i < 72; i++) begin
      cycle(i == 0, 32'hD0, 0);
      if (req && r0 < 0) r0 = i;
      if (starve && s0 < 0) s0 = i;
    end
    chk("t4_starve_delay", s0 - r0, 64);
    cycle(0, '0, 1);
    chk("t4_starve_clr", starve, 0);
    repeat (10) cycle(0, '0, req);

    // Fill to full, then keep offering words while bursts drain
    beat_log.delete();
    for (int i = 0; i < 8; i++) cycle(1, 32'hE0 + i, 0);
    chk("t5_full", in_ready, 0);
    cycle(1, 32'hFF, 0);
    chk("t5_still_full", in_ready, 0);
    idx = 0;
    for (int i = 0; i < 30; i++) begin
      rdy = in_ready;
      cycle(1, 32'hE8 + idx, req);
      if (rdy) idx++;
    end
    repeat (30) cycle(0, '0, req);
    chk("t5_count", beat_log.size(), 8 + idx);
    foreach (beat_log[i]) chk("t5_order", beat_log[i][DATA_W-1:0], 32'hE0 + i);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) cycle(1, 32'h60 + i, 0);
    k = 0;
    while (!bus_valid && k < 10) begin cycle(0, '0, req); k++; end
    chk("t6_burst_started", bus_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req", req, 0);
    chk("t6_bus_valid", bus_valid, 0);
    chk("t6_bus_data", bus_data, 0);
    chk("t6_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    beat_log.delete();
    repeat (10) cycle(0, '0, req);
    chk("t6_no_beats", beat_log.size(), 0);

    // Randomized traffic with a loosely behaved arbiter
    for (int i = 0; i < 2000; i++) begin
      g = req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      cycle(1'($urandom_range(0, 1)), $urandom, g[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
